centroid_motion_estimator: RTL

Downstream consumer of the temporal accumulator's window snapshot (accum_valid pulse plus early/late Σx, Σy and count). It computes fixed-point early and late centroids with one shared iterative restoring divider, then forms the motion vector (late − early). The vector is classified into a swipe direction with a confidence value and presented as a single-cycle result pulse to the gesture output/UART stage.

---
 rtl/gesture_pkg.sv | 29 ++
 rtl/seq_divider.sv | 91 +++++++++
 rtl/centroid_motion_estimator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/gesture_pkg.sv
// ----------------------------------------------------------------------------
// gesture_pkg
// Shared types and defaults for the gesture pipeline.
//   dir_t          : swipe direction code presented to the output/UART stage
//   FRAC_BITS      : fractional bits of centroid values
//   MIN_EVENTS     : minimum events per half-window for a valid estimate
//   MOTION_THRESH  : minimum |delta| (Q.FRAC units) to report motion
//   CENT_BITS      : signed centroid width, Q(GRID_BITS).FRAC_BITS
//   DELTA_BITS     : signed motion-vector width (one bit wider than a centroid)
// ----------------------------------------------------------------------------
package gesture_pkg;

    localparam int unsigned GRID_BITS     = 4;
    localparam int unsigned FRAC_BITS     = 4;
    localparam int unsigned MIN_EVENTS    = 8;
    localparam int unsigned MOTION_THRESH = 32;

    localparam int unsigned CENT_BITS  = GRID_BITS + 1 + FRAC_BITS;
    localparam int unsigned DELTA_BITS = CENT_BITS + 1;

    typedef enum logic [2:0] {
        DirNone  = 3'd0,
        DirRight = 3'd1,
        DirLeft  = 3'd2,
        DirUp    = 3'd3,
        DirDown  = 3'd4
    } dir_t;

endpackage

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per cycle, DIVIDEND_BITS cycles
// per divide. The start cycle already performs the first iteration, so done
// pulses exactly DIVIDEND_BITS cycles after start; the quotient is held until
// the next start. A start may be issued in the same cycle as done.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (aborts a divide)
//   i_start      : load operands and begin a divide
//   i_dividend   : unsigned dividend, sampled with i_start
//   i_divisor    : unsigned divisor, sampled with i_start (must be non-zero)
//   o_done       : one-cycle pulse when the quotient is ready
//   o_quotient   : low QUOTIENT_BITS of the quotient
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned DIVIDEND_BITS = 21,
    parameter int unsigned DIVISOR_BITS  = 12,
    parameter int unsigned QUOTIENT_BITS = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [DIVIDEND_BITS-1:0] i_dividend,
    input  logic [DIVISOR_BITS-1:0]  i_divisor,
    output logic                     o_done,
    output logic [QUOTIENT_BITS-1:0] o_quotient
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_BITS + 1);

    // r_quot doubles as the dividend shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    logic [DIVIDEND_BITS-1:0] r_quot;
    logic [DIVISOR_BITS-1:0]  r_rem;
    logic [DIVISOR_BITS-1:0]  r_divisor;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_busy;
    logic                     r_done;

    logic [DIVIDEND_BITS-1:0] w_q_src;
    logic [DIVISOR_BITS-1:0]  w_rem_src;
    logic [DIVISOR_BITS-1:0]  w_div_src;
    logic [DIVISOR_BITS:0]    w_rem_shift;
    logic                     w_fits;
    logic [DIVISOR_BITS-1:0]  w_rem_next;
    logic [DIVIDEND_BITS-1:0] w_q_next;

    always_comb begin
        w_q_src     = i_start ? i_dividend : r_quot;
        w_rem_src   = i_start ? '0 : r_rem;
        w_div_src   = i_start ? i_divisor : r_divisor;
        w_rem_shift = {w_rem_src, w_q_src[DIVIDEND_BITS-1]};
        w_fits      = w_rem_shift >= {1'b0, w_div_src};
        // Restore by keeping the shifted remainder when the trial subtract fails.
        w_rem_next  = w_fits ? DIVISOR_BITS'(w_rem_shift - {1'b0, w_div_src})
                             : w_rem_shift[DIVISOR_BITS-1:0];
        w_q_next    = {w_q_src[DIVIDEND_BITS-2:0], w_fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quot    <= w_q_next;
                r_rem     <= w_rem_next;
                r_divisor <= i_divisor;
                r_cnt     <= CNT_W'(DIVIDEND_BITS - 1);
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                r_quot <= w_q_next;
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quot[QUOTIENT_BITS-1:0];

endmodule

// File: rtl/centroid_motion_estimator.sv
// ----------------------------------------------------------------------------
// centroid_motion_estimator
// Consumes a window snapshot (early/late sums and counts), computes the early
// and late centroids with one shared sequential divider, forms the motion
// vector late - early and classifies it into a swipe direction.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_accum_valid                  : snapshot pulse; sums/counts sampled here
//   i_early_sum_x/_y, i_early_count: early half-window sums and event count
//   i_late_sum_x/_y,  i_late_count : late half-window sums and event count
//   o_early_cx/_cy, o_late_cx/_cy  : signed centroids, Q(GRID_BITS).FRAC_BITS
//   o_delta_x/_y                   : signed late - early
//   o_direction                    : gesture_pkg::dir_t code
//   o_confidence                   : min(counts) >> 4, saturated at 255
//   o_result_valid                 : one-cycle result pulse
//   o_busy                         : snapshot in progress (snapshots dropped)
//   o_drop_count                   : saturating count of dropped snapshots
// ----------------------------------------------------------------------------
module centroid_motion_estimator #(
    parameter int unsigned GRID_BITS      = gesture_pkg::GRID_BITS,
    parameter int unsigned ACC_SUM_BITS   = 18,
    parameter int unsigned ACC_COUNT_BITS = 12,
    parameter int unsigned FRAC_BITS      = gesture_pkg::FRAC_BITS,
    parameter int unsigned DIV_BITS       = ACC_SUM_BITS - 1 + FRAC_BITS,
    parameter int unsigned MIN_EVENTS     = gesture_pkg::MIN_EVENTS,
    parameter int unsigned MOTION_THRESH  = gesture_pkg::MOTION_THRESH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_accum_valid,
    input  logic [ACC_SUM_BITS-1:0]          i_early_sum_x,
    input  logic [ACC_SUM_BITS-1:0]          i_early_sum_y,
    input  logic [ACC_COUNT_BITS-1:0]        i_early_count,
    input  logic [ACC_SUM_BITS-1:0]          i_late_sum_x,
    input  logic [ACC_SUM_BITS-1:0]          i_late_sum_y,
    input  logic [ACC_COUNT_BITS-1:0]        i_late_count,
    output logic [GRID_BITS+FRAC_BITS:0]     o_early_cx,
    output logic [GRID_BITS+FRAC_BITS:0]     o_early_cy,
    output logic [GRID_BITS+FRAC_BITS:0]     o_late_cx,
    output logic [GRID_BITS+FRAC_BITS:0]     o_late_cy,
    output logic [GRID_BITS+FRAC_BITS+1:0]   o_delta_x,
    output logic [GRID_BITS+FRAC_BITS+1:0]   o_delta_y,
    output logic [2:0]                       o_direction,
    output logic [7:0]                       o_confidence,
    output logic                             o_result_valid,
    output logic                             o_busy,
    output logic [7:0]                       o_drop_count
);

    import gesture_pkg::*;

    localparam int unsigned CW = GRID_BITS + 1 + FRAC_BITS;
    localparam int unsigned DW = CW + 1;

    typedef enum logic [1:0] {StIdle, StCheck, StDiv, StClassify} state_t;

    state_t                    r_state;
    logic [ACC_SUM_BITS-1:0]   r_early_sx, r_early_sy, r_late_sx, r_late_sy;
    logic [ACC_COUNT_BITS-1:0] r_early_cnt, r_late_cnt;
    logic [1:0]                r_idx;
    // Working centroids, in divide order: early_x, early_y, late_x, late_y.
    logic [CW-1:0]             r_cent [4];
    logic [CW-1:0]             r_out_ecx, r_out_ecy, r_out_lcx, r_out_lcy;
    logic [DW-1:0]             r_out_dx, r_out_dy;
    dir_t                      r_out_dir;
    logic [7:0]                r_out_conf;
    logic [7:0]                r_drop;
    logic                      r_result_valid;
    logic                      r_busy;

    logic [ACC_SUM_BITS-1:0]   w_sums [4];
    logic                      w_counts_ok;
    logic [1:0]                w_op_idx;
    logic [ACC_SUM_BITS-1:0]   w_op_sum, w_op_abs;
    logic [ACC_COUNT_BITS-1:0] w_op_divisor;
    logic [DIV_BITS-1:0]       w_dividend;
    logic                      w_div_start, w_div_done;
    logic [CW-1:0]             w_quot, w_cent_signed;
    logic [DW-1:0]             w_dx, w_dy, w_adx, w_ady;
    dir_t                      w_dir;
    logic [ACC_COUNT_BITS-1:0] w_min_cnt, w_conf_full;
    logic [7:0]                w_conf;

    assign w_sums[0] = r_early_sx;
    assign w_sums[1] = r_early_sy;
    assign w_sums[2] = r_late_sx;
    assign w_sums[3] = r_late_sy;

    // Divider operand selection and sign restoration.
    always_comb begin
        w_counts_ok  = (r_early_cnt >= ACC_COUNT_BITS'(MIN_EVENTS)) &&
                       (r_late_cnt >= ACC_COUNT_BITS'(MIN_EVENTS));
        // Operands for the divide about to start: the first one from CHECK,
        // the next one when the current divide completes.
        w_op_idx     = (r_state == StCheck) ? 2'd0 : r_idx + 2'd1;
        w_op_sum     = w_sums[w_op_idx];
        w_op_abs     = w_op_sum[ACC_SUM_BITS-1] ? -w_op_sum : w_op_sum;
        w_dividend   = DIV_BITS'({w_op_abs, {FRAC_BITS{1'b0}}});
        w_op_divisor = w_op_idx[1] ? r_late_cnt : r_early_cnt;
        w_div_start  = ((r_state == StCheck) && w_counts_ok) ||
                       ((r_state == StDiv) && w_div_done && (r_idx != 2'd3));
        // Negating the magnitude quotient gives truncation toward zero.
        w_cent_signed = w_sums[r_idx][ACC_SUM_BITS-1] ? -w_quot : w_quot;
    end

    // Motion vector, direction and confidence.
    always_comb begin
        w_dx  = {r_cent[2][CW-1], r_cent[2]} - {r_cent[0][CW-1], r_cent[0]};
        w_dy  = {r_cent[3][CW-1], r_cent[3]} - {r_cent[1][CW-1], r_cent[1]};
        w_adx = w_dx[DW-1] ? -w_dx : w_dx;
        w_ady = w_dy[DW-1] ? -w_dy : w_dy;
        w_dir = DirNone;
        // >= on the horizontal test makes a tie resolve horizontally.
        if ((w_adx >= w_ady) && (w_adx >= DW'(MOTION_THRESH))) begin
            w_dir = w_dx[DW-1] ? DirLeft : DirRight;
        end else if (w_ady >= DW'(MOTION_THRESH)) begin
            w_dir = w_dy[DW-1] ? DirDown : DirUp;
        end
        w_min_cnt   = (r_early_cnt < r_late_cnt) ? r_early_cnt : r_late_cnt;
        w_conf_full = w_min_cnt >> 4;
        w_conf      = (w_conf_full > ACC_COUNT_BITS'(255)) ? 8'hFF : w_conf_full[7:0];
    end

    seq_divider #(
        .DIVIDEND_BITS (DIV_BITS),
        .DIVISOR_BITS  (ACC_COUNT_BITS),
        .QUOTIENT_BITS (CW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_op_divisor),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_early_sx     <= '0;
            r_early_sy     <= '0;
            r_late_sx      <= '0;
            r_late_sy      <= '0;
            r_early_cnt    <= '0;
            r_late_cnt     <= '0;
            r_idx          <= '0;
            for (int i = 0; i < 4; i++) r_cent[i] <= '0;
            r_out_ecx      <= '0;
            r_out_ecy      <= '0;
            r_out_lcx      <= '0;
            r_out_lcy      <= '0;
            r_out_dx       <= '0;
            r_out_dy       <= '0;
            r_out_dir      <= DirNone;
            r_out_conf     <= '0;
            r_drop         <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (i_accum_valid && (r_state != StIdle) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            case (r_state)
                StIdle: begin
                    if (i_accum_valid) begin
                        r_early_sx  <= i_early_sum_x;
                        r_early_sy  <= i_early_sum_y;
                        r_early_cnt <= i_early_count;
                        r_late_sx   <= i_late_sum_x;
                        r_late_sy   <= i_late_sum_y;
                        r_late_cnt  <= i_late_count;
                        // Zeroed here so the insufficient-count path reports 0.
                        for (int i = 0; i < 4; i++) r_cent[i] <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= StCheck;
                    end
                end
                StCheck: begin
                    r_idx   <= 2'd0;
                    r_state <= w_counts_ok ? StDiv : StClassify;
                end
                StDiv: begin
                    if (w_div_done) begin
                        r_cent[r_idx] <= w_cent_signed;
                        if (r_idx == 2'd3) begin
                            r_state <= StClassify;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                StClassify: begin
                    r_out_ecx      <= r_cent[0];
                    r_out_ecy      <= r_cent[1];
                    r_out_lcx      <= r_cent[2];
                    r_out_lcy      <= r_cent[3];
                    r_out_dx       <= w_dx;
                    r_out_dy       <= w_dy;
                    r_out_dir      <= w_dir;
                    r_out_conf     <= w_conf;
                    r_result_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_early_cx     = r_out_ecx;
    assign o_early_cy     = r_out_ecy;
    assign o_late_cx      = r_out_lcx;
    assign o_late_cy      = r_out_lcy;
    assign o_delta_x      = r_out_dx;
    assign o_delta_y      = r_out_dy;
    assign o_direction    = r_out_dir;
    assign o_confidence   = r_out_conf;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
    assign o_drop_count   = r_drop;

endmodule
